conv_window_gen: RTL

- Parametrised sliding-window generator for the convolution front end.
- Captures one IMG_H x IMG_W tensor through a valid/ready handshake and buffers it internally.
- Streams every zero-padded K x K window (with configurable stride) to the MAC array, repeating the full scan N_PASSES times (one per filter).
- Output backpressure is honoured; done pulses after the last window of the last pass.

---
 rtl/conv_window_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: sliding-window generator for the convolution front end.
// Captures one IMG_H x IMG_W tensor, then streams every zero-padded K x K
// window (row-major, STRIDE step) N_PASSES times, once per filter.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready tensor capture handshake (in_tensor, pixel (r,c) at
//                     bits [((r*IMG_W)+c)*DATA_W +: DATA_W])
//   win_valid/ready   window handshake; win_data element (i,j) at
//                     bits [((i*K)+j)*DATA_W +: DATA_W]
//   win_row/col/pass  position of the presented window and filter pass
//   win_last          last window of the current pass
//   done              one-cycle pulse after the final window of the final pass

// One window element: picks buffer[y][x] for the current position, or zero
// when the tap lands in the padding border.
module conv_win_tap #(
  parameter int DATA_W = 8,
  parameter int IMG_H  = 8,
  parameter int IMG_W  = 8,
  parameter int PAD    = 1,
  parameter int STRIDE = 1,
  parameter int RW     = 3,
  parameter int CW     = 3,
  parameter int I      = 0,
  parameter int J      = 0
) (
  input  logic [IMG_H*IMG_W*DATA_W-1:0] img,
  input  logic [RW-1:0]                 row,
  input  logic [CW-1:0]                 col,
  output logic [DATA_W-1:0]             pix
);
  int y, x;

  // Signed 32-bit coordinates so the -PAD border never aliases into the image.
  always_comb begin
    y   = int'(row) * STRIDE + I - PAD;
    x   = int'(col) * STRIDE + J - PAD;
    pix = '0;
    if (y >= 0 && y < IMG_H && x >= 0 && x < IMG_W)
      pix = img[(y * IMG_W + x) * DATA_W +: DATA_W];
  end
endmodule

module conv_window_gen #(
  parameter int DATA_W   = 8,
  parameter int IMG_H    = 8,
  parameter int IMG_W    = 8,
  parameter int K        = 3,
  parameter int PAD      = 1,
  parameter int STRIDE   = 1,
  parameter int N_PASSES = 3,
  localparam int OUT_H   = (IMG_H + 2*PAD - K) / STRIDE + 1,
  localparam int OUT_W   = (IMG_W + 2*PAD - K) / STRIDE + 1,
  localparam int RW      = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW      = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int PW      = (N_PASSES > 1) ? $clog2(N_PASSES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IMG_H*IMG_W*DATA_W-1:0] in_tensor,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [K*K*DATA_W-1:0]         win_data,
  output logic [RW-1:0]                 win_row,
  output logic [CW-1:0]                 win_col,
  output logic [PW-1:0]                 win_pass,
  output logic                          win_last,
  output logic                          done
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [RW-1:0]                   row_q, row_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [PW-1:0]                   pass_q, pass_d;
  logic [IMG_H*IMG_W*DATA_W-1:0]   img_q, img_d;

  logic last_col, last_row, last_pass;
  assign last_col  = (col_q  == CW'(OUT_W - 1));
  assign last_row  = (row_q  == RW'(OUT_H - 1));
  assign last_pass = (pass_q == PW'(N_PASSES - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pass_d  = pass_q;
    img_d   = img_q;
    case (state_q)
      S_IDLE: begin
        // Buffer is only ever written here, so the tensor is frozen while scanning.
        if (in_valid) begin
          img_d   = in_tensor;
          row_d   = '0;
          col_d   = '0;
          pass_d  = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (win_ready) begin
          if (!last_col) begin
            col_d = col_q + CW'(1);
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_q + RW'(1);
            end else begin
              row_d = '0;
              if (!last_pass) begin
                pass_d = pass_q + PW'(1);
              end else begin
                pass_d  = '0;
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pass_q  <= '0;
      img_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pass_q  <= pass_d;
      img_q   <= img_d;
    end
  end

  // Handshake/status outputs are straight decodes of the state flop.
  assign in_ready  = (state_q == S_IDLE);
  assign win_valid = (state_q == S_SCAN);
  assign done      = (state_q == S_DONE);
  assign win_last  = win_valid && last_row && last_col;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign win_pass  = pass_q;

  // Window is combinational from buffer + counters: no extra latency, and it
  // holds still under stall because the counters only move on a fire.
  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      conv_win_tap #(
        .DATA_W(DATA_W), .IMG_H(IMG_H), .IMG_W(IMG_W), .PAD(PAD),
        .STRIDE(STRIDE), .RW(RW), .CW(CW), .I(gi), .J(gj)
      ) u_tap (
        .img (img_q),
        .row (row_q),
        .col (col_q),
        .pix (win_data[(gi*K + gj)*DATA_W +: DATA_W])
      );
    end
  end
endmodule
